// File: rtl/wb_pkg.sv
// Shared types for the pipelined Wishbone master: FSM state and response status.
package wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RSP  = 2'd3
  } wb_state_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_ERR     = 2'b01,
    RSP_TIMEOUT = 2'b10
  } wb_status_e;

  // Error wins over ack; neither means the transfer was abandoned by the watchdog.
  function automatic wb_status_e resp_status(input logic ack, input logic err);
    if (err) begin
      return RSP_ERR;
    end else if (ack) begin
      return RSP_OK;
    end
    return RSP_TIMEOUT;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Cycle counter that flags a bus transfer which has run too long without a reply.
// expired_o is high during the TIMEOUT-th consecutive cycle of run_i.
// TIMEOUT = 0 disables the watchdog entirely.
module wb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic          ENABLED  = (TIMEOUT != 0);

  logic [CW-1:0] r_cnt;

  assign expired_o = ENABLED && run_i && (r_cnt == CNT_LAST);

  // Count running cycles; clear restarts the count for a new transfer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (run_i && !expired_o) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wb_p_master.sv
// Single-outstanding Wishbone pipelined master: turns one command into one bus
// transfer and returns one response (data + status).
//
// Handshakes: a transfer on cmd_* or rsp_* happens on a rising edge where both
// valid and ready are high. A producer holds valid and its payload stable until
// that edge; ready may change freely and never depends on a future valid.
module wb_p_master import wb_pkg::*; #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  localparam int SEL_W  = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [SEL_W-1:0]  cmd_sel_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic [1:0]        rsp_status_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_stall_i,
  output logic [1:0]        dbg_state_o
);

  wb_state_e         r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_dat;
  logic [DATA_W-1:0] r_rdata;
  wb_status_e        r_status;

  wb_state_e         w_state_nxt;
  logic              w_accept;
  logic              w_done;
  logic              w_hit;
  logic              w_run;
  logic              w_expired;
  wb_status_e        w_status_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;

  assign w_run = (r_state == S_REQ) || (r_state == S_WAIT);

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .run_i    (w_run),
    .clear_i  (w_accept),
    .expired_o(w_expired)
  );

  // Next state plus the capture strobes for command and response registers.
  // ack/err only count while a request is on the bus and accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_hit       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_hit = !wb_stall_i && (wb_ack_i || wb_err_i);
        if (w_hit || w_expired) begin
          w_done      = 1'b1;
          w_state_nxt = S_RSP;
        end else if (!wb_stall_i) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_hit = wb_ack_i || wb_err_i;
        if (w_hit || w_expired) begin
          w_done      = 1'b1;
          w_state_nxt = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_status_nxt = resp_status(w_hit && wb_ack_i, w_hit && wb_err_i);
    w_rdata_nxt  = (w_status_nxt == RSP_OK && !r_we) ? wb_dat_i : '0;
  end

  // State register; reset also abandons any transfer in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command fields latched on accept, response latched on completion.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_sel    <= '0;
      r_dat    <= '0;
      r_rdata  <= '0;
      r_status <= RSP_OK;
    end else begin
      if (w_accept) begin
        r_we  <= cmd_we_i;
        r_adr <= cmd_addr_i;
        r_sel <= cmd_sel_i;
        r_dat <= cmd_wdata_i;
      end
      if (w_done) begin
        r_rdata  <= w_rdata_nxt;
        r_status <= w_status_nxt;
      end
    end
  end

  // Bus and handshake outputs are decoded straight from the state register,
  // so cyc drops on the very edge that enters RSP or sees reset.
  assign cmd_ready_o  = rst_ni && (r_state == S_IDLE);
  assign rsp_valid_o  = (r_state == S_RSP);
  assign rsp_rdata_o  = r_rdata;
  assign rsp_status_o = r_status;
  assign wb_cyc_o     = w_run;
  assign wb_stb_o     = (r_state == S_REQ);
  assign wb_we_o      = r_we;
  assign wb_adr_o     = r_adr;
  assign wb_sel_o     = r_sel;
  assign wb_dat_o     = r_dat;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_wb_p_master.sv
// Bench for wb_p_master: a behavioural pipelined slave with configurable stall,
// latency and reply kind, a reference memory, and a response scoreboard.
module tb_wb_p_master;

  logic        clk_i;
  logic        rst_ni;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_status_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i, wb_stall_i;
  logic [1:0]  dbg_state_o;

  int total = 0;
  int bad   = 0;
  logic [33:0] exp_q[$];   // {status, rdata}

  // slave knobs and state
  int          sl_stall_cfg = 0;
  int          sl_wait_cfg  = 0;
  int          sl_mode      = 0;  // 0 ack, 1 silent, 2 ack+err
  bit          sl_spurious  = 0;
  bit          sl_unstable  = 0;
  int          sl_stb_cnt   = 0;
  bit          sl_seen = 0, sl_busy = 0, sl_respond;
  int          sl_cnt, sl_lat;
  logic        sl_f_we;
  logic [31:0] sl_f_adr, sl_f_dat;
  logic [3:0]  sl_f_sel;
  logic [31:0] sl_mem [8];
  logic [31:0] ref_mem[8];

  wb_p_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_sel_i(cmd_sel_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_status_o(rsp_status_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_stall_i(wb_stall_i), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #400000;
    $display("FAIL sim_timeout: run exceeded time limit");
    $fatal(1, "time limit");
  end

  // Behavioural slave: reacts 2 time units after each edge to what the master drives.
  always @(posedge clk_i) begin
    #2;
    wb_ack_i = 0; wb_err_i = 0; wb_stall_i = 0; wb_dat_i = '0;
    sl_respond = 0;
    if (!wb_cyc_o) begin
      sl_seen = 0; sl_busy = 0;
    end else if (wb_stb_o) begin
      sl_stb_cnt++;
      if (!sl_seen) begin
        sl_seen = 1; sl_cnt = sl_stall_cfg;
        sl_f_we = wb_we_o; sl_f_adr = wb_adr_o; sl_f_sel = wb_sel_o; sl_f_dat = wb_dat_o;
      end else if (sl_f_we !== wb_we_o || sl_f_adr !== wb_adr_o ||
                   sl_f_sel !== wb_sel_o || sl_f_dat !== wb_dat_o) begin
        sl_unstable = 1;
      end
      if (sl_cnt > 0) begin
        wb_stall_i = 1; sl_cnt--;
      end else begin
        sl_busy = 1; sl_lat = sl_wait_cfg;
        if (sl_lat == 0) sl_respond = 1;
      end
    end else if (sl_busy) begin
      if (sl_lat > 0) sl_lat--;
      if (sl_lat == 0) sl_respond = 1;
    end
    if (sl_respond && sl_mode != 1) begin
      wb_ack_i = 1;
      if (sl_mode == 2) begin
        wb_err_i = 1;
      end else if (sl_f_we) begin
        for (int b = 0; b < 4; b++)
          if (sl_f_sel[b]) sl_mem[sl_f_adr[4:2]][8*b +: 8] = sl_f_dat[8*b +: 8];
      end else begin
        wb_dat_i = sl_mem[sl_f_adr[4:2]];
      end
    end
    if (sl_spurious) wb_ack_i = 1;
  end

  // driver: present a command and hold it through the handshake edge
  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input logic [33:0] exp, input bit push);
    int n;
    if (push) exp_q.push_back(exp);
    cmd_valid_i = 1; cmd_we_i = we; cmd_addr_i = adr; cmd_sel_i = sel; cmd_wdata_i = dat;
    n = 0;
    while (!cmd_ready_o && n < 40) begin @(posedge clk_i); #1; n++; end
    total++;
    if (!cmd_ready_o) begin
      bad++; $display("FAIL cmd_accept: cmd_ready_o=0 after %0d cycles, required 1", n);
    end
    @(posedge clk_i); #1;
    cmd_valid_i = 0;
  endtask

  // scoreboard: take one response and compare it with the oldest expectation
  task automatic get_rsp(input string name);
    int n;
    logic [33:0] exp;
    rsp_ready_i = 1;
    n = 0;
    while (!rsp_valid_o && n < 40) begin @(posedge clk_i); #1; n++; end
    total++;
    if (!rsp_valid_o) begin
      bad++; $display("FAIL %s_rsp_valid: no response after %0d cycles", name, n);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      rsp_ready_i = 0;
      return;
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++; $display("FAIL %s_unexpected: response with empty expected queue", name);
    end else begin
      exp = exp_q.pop_front();
      if (rsp_status_o !== exp[33:32]) begin
        bad++; $display("FAIL %s_status: got %b expected %b", name, rsp_status_o, exp[33:32]);
      end
      total++;
      if (rsp_rdata_o !== exp[31:0]) begin
        bad++; $display("FAIL %s_rdata: got %h expected %h", name, rsp_rdata_o, exp[31:0]);
      end
    end
    @(posedge clk_i); #1;
    rsp_ready_i = 0;
    total++;
    if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      bad++; $display("FAIL %s_return_idle: rsp_valid=%b cmd_ready=%b expected 0/1",
                      name, rsp_valid_o, cmd_ready_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 0;
    repeat (3) @(posedge clk_i);
    #1;
    total++;
    if ({cmd_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o} !== 5'b0 ||
        wb_adr_o !== 32'h0 || wb_sel_o !== 4'h0 || wb_dat_o !== 32'h0 ||
        rsp_rdata_o !== 32'h0 || rsp_status_o !== 2'b00 || dbg_state_o !== 2'd0) begin
      bad++; $display("FAIL reset_values: rdy=%b cyc=%b stb=%b we=%b rv=%b adr=%h sel=%h dat=%h rd=%h st=%b, all required 0",
                      cmd_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o,
                      wb_adr_o, wb_sel_o, wb_dat_o, rsp_rdata_o, rsp_status_o);
    end
    rst_ni = 1;
    #1;
    total++;
    if (cmd_ready_o !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: cmd_ready_o=%b required 1", cmd_ready_o);
    end
  endtask

  task automatic test_write();
    sl_mode = 0; sl_stall_cfg = 0; sl_wait_cfg = 0; sl_stb_cnt = 0;
    send_cmd(1, 32'h4, 4'hf, 32'hDEADBEEF, {2'b00, 32'h0}, 1);
    total++;
    if (wb_cyc_o !== 1 || wb_stb_o !== 1 || wb_we_o !== 1 || wb_adr_o !== 32'h4 ||
        wb_sel_o !== 4'hf || wb_dat_o !== 32'hDEADBEEF || rsp_valid_o !== 0) begin
      bad++; $display("FAIL write_fields: cyc=%b stb=%b we=%b adr=%h sel=%h dat=%h rv=%b",
                      wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, rsp_valid_o);
    end
    @(posedge clk_i); #1;
    total++;
    if (rsp_valid_o !== 1 || wb_cyc_o !== 0) begin
      bad++; $display("FAIL write_latency: rsp_valid=%b cyc=%b expected 1/0", rsp_valid_o, wb_cyc_o);
    end
    get_rsp("write");
    total++;
    if (sl_stb_cnt !== 1) begin
      bad++; $display("FAIL write_stb_count: got %0d expected 1", sl_stb_cnt);
    end
  endtask

  task automatic test_read_stall();
    int n, stb_n;
    sl_mem[2] = 32'h12345678;
    sl_mode = 0; sl_stall_cfg = 3; sl_wait_cfg = 2; sl_unstable = 0;
    send_cmd(0, 32'h8, 4'hf, 32'h0, {2'b00, 32'h12345678}, 1);
    n = 0; stb_n = 0;
    while (!rsp_valid_o && n < 40) begin
      if (wb_stb_o) stb_n++;
      @(posedge clk_i); #1; n++;
    end
    total++;
    if (stb_n != 4) begin
      bad++; $display("FAIL read_stb_cycles: got %0d expected 4", stb_n);
    end
    total++;
    if (sl_unstable !== 0) begin
      bad++; $display("FAIL read_field_stable: request changed while stalled");
    end
    get_rsp("read_stall");
  endtask

  task automatic test_timeout();
    int n, cyc_n;
    sl_mode = 1; sl_stall_cfg = 0; sl_wait_cfg = 0;
    send_cmd(0, 32'h10, 4'hf, 32'h0, {2'b10, 32'h0}, 1);
    n = 0; cyc_n = 0;
    while (!rsp_valid_o && n < 40) begin
      if (wb_cyc_o) cyc_n++;
      @(posedge clk_i); #1; n++;
    end
    total++;
    if (cyc_n != 16) begin
      bad++; $display("FAIL timeout_cycles: got %0d expected 16", cyc_n);
    end
    total++;
    if (wb_cyc_o !== 0) begin
      bad++; $display("FAIL timeout_cyc_drop: cyc=%b expected 0", wb_cyc_o);
    end
    get_rsp("timeout");
    sl_mode = 0;
  endtask

  task automatic test_ack_err();
    sl_mode = 2; sl_stall_cfg = 0; sl_wait_cfg = 1;
    send_cmd(0, 32'h8, 4'hf, 32'h0, {2'b01, 32'h0}, 1);
    get_rsp("ack_err");
    sl_mode = 0;
  endtask

  task automatic test_spurious();
    sl_spurious = 1;
    repeat (3) begin
      @(posedge clk_i); #1;
      total++;
      if (rsp_valid_o !== 0 || cmd_ready_o !== 1 || dbg_state_o !== 2'd0) begin
        bad++; $display("FAIL spurious_ack: rsp_valid=%b cmd_ready=%b state=%0d expected 0/1/0",
                        rsp_valid_o, cmd_ready_o, dbg_state_o);
      end
    end
    sl_spurious = 0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_backpressure();
    sl_mode = 0; sl_stall_cfg = 0; sl_wait_cfg = 0;
    send_cmd(0, 32'h4, 4'hf, 32'h0, {2'b00, 32'hDEADBEEF}, 1);
    @(posedge clk_i); #1;
    cmd_valid_i = 1; cmd_we_i = 1; cmd_addr_i = 32'h1C; cmd_sel_i = 4'hf; cmd_wdata_i = 32'h55AA55AA;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid_o !== 1 || rsp_rdata_o !== 32'hDEADBEEF || rsp_status_o !== 2'b00 ||
          cmd_ready_o !== 0 || wb_stb_o !== 0) begin
        bad++; $display("FAIL hold_rsp[%0d]: rv=%b rd=%h st=%b rdy=%b stb=%b expected 1/deadbeef/00/0/0",
                        i, rsp_valid_o, rsp_rdata_o, rsp_status_o, cmd_ready_o, wb_stb_o);
      end
      @(posedge clk_i); #1;
    end
    cmd_valid_i = 0;
    get_rsp("backpressure");
  endtask

  task automatic test_reset_wait();
    sl_mode = 1; sl_stall_cfg = 0; sl_wait_cfg = 0;
    send_cmd(0, 32'h8, 4'hf, 32'h0, 34'h0, 0);
    @(posedge clk_i); #1;
    total++;
    if (wb_cyc_o !== 1 || wb_stb_o !== 0) begin
      bad++; $display("FAIL rst_wait_state: cyc=%b stb=%b expected 1/0", wb_cyc_o, wb_stb_o);
    end
    rst_ni = 0;
    @(posedge clk_i); #1;
    total++;
    if (wb_cyc_o !== 0 || rsp_valid_o !== 0 || cmd_ready_o !== 0) begin
      bad++; $display("FAIL rst_wait_drop: cyc=%b rv=%b rdy=%b expected 0/0/0",
                      wb_cyc_o, rsp_valid_o, cmd_ready_o);
    end
    rst_ni = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      total++;
      if (rsp_valid_o !== 0 || wb_cyc_o !== 0) begin
        bad++; $display("FAIL rst_wait_quiet[%0d]: rv=%b cyc=%b expected 0/0", i, rsp_valid_o, wb_cyc_o);
      end
    end
    sl_mode = 0;
  endtask

  task automatic test_random();
    logic [2:0]  idx;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [33:0] exp;
    for (int i = 0; i < 8; i++) begin sl_mem[i] = '0; ref_mem[i] = '0; end
    sl_mode = 0; sl_unstable = 0;
    for (int i = 0; i < 32; i++) begin
      idx = 3'($urandom_range(0, 7));
      we  = 1'($urandom_range(0, 1));
      sel = we ? 4'($urandom_range(1, 15)) : 4'hf;
      dat = $urandom;
      sl_stall_cfg = $urandom_range(0, 3);
      sl_wait_cfg  = $urandom_range(0, 3);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
        exp = {2'b00, 32'h0};
      end else begin
        exp = {2'b00, ref_mem[idx]};
      end
      send_cmd(we, {27'h0, idx, 2'b00}, sel, dat, exp, 1);
      get_rsp("random");
    end
    total++;
    if (sl_unstable !== 0) begin
      bad++; $display("FAIL random_field_stable: request changed while stalled");
    end
  endtask

  initial begin
    rst_ni = 0; cmd_valid_i = 0; cmd_we_i = 0; cmd_addr_i = '0; cmd_sel_i = '0; cmd_wdata_i = '0;
    rsp_ready_i = 0; wb_dat_i = '0; wb_ack_i = 0; wb_err_i = 0; wb_stall_i = 0;
    for (int i = 0; i < 8; i++) sl_mem[i] = '0;
    test_reset();
    test_write();
    test_read_stall();
    test_timeout();
    test_ack_err();
    test_spurious();
    test_backpressure();
    test_reset_wait();
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL leftover_expected: %0d responses never seen", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
